// File: rtl/prbs_checker_if.sv
// Serial stream into the PRBS checker and the checker's lock/error status back out.
interface prbs_checker_if;
   logic        in_valid;
   logic        in_bit;
   logic        locked;
   logic        err_pulse;
   logic [15:0] err_count;
   logic [15:0] bit_count;

   modport master (
      output in_valid, in_bit,
      input  locked, err_pulse, err_count, bit_count
   );

   modport slave (
      input  in_valid, in_bit,
      output locked, err_pulse, err_count, bit_count
   );
endinterface

// File: rtl/prbs_checker.sv
// Self-seeding checker for the 8-bit nonlinear PRBS; one bit per cycle, no backpressure.
// All outputs registered: err_pulse/counters update on the edge that accepts the bit.
module prbs_checker #(
   parameter int WIN_LEN     = 16,
   parameter int LOSS_THRESH = 4
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          clear,
   prbs_checker_if.slave mon
);

   typedef enum logic {
      SEED   = 1'b0,
      LOCKED = 1'b1
   } state_t;

   localparam logic [7:0] WIN_LEN_C = 8'(WIN_LEN);
   localparam logic [7:0] LOSS_C    = 8'(LOSS_THRESH);

   state_t      state_q, state_d;
   logic [7:0]  w_q, w_d;
   logic [2:0]  seed_cnt_q, seed_cnt_d;
   logic [7:0]  win_bits_q, win_bits_d;
   logic [7:0]  win_err_q, win_err_d;
   logic        err_pulse_q, err_pulse_d;
   logic [15:0] err_count_q, err_count_d;
   logic [15:0] bit_count_q, bit_count_d;

   logic        exp_bit;
   logic        mismatch;
   logic [7:0]  win_bits_inc;
   logic [7:0]  win_err_inc;

   // W[0] is the oldest bit; prediction uses the window before the new bit shifts in.
   assign exp_bit      = (^w_q[3:0]) ^ ~(|w_q[7:1]);
   assign mismatch     = mon.in_bit ^ exp_bit;
   assign win_bits_inc = win_bits_q + 8'd1;
   assign win_err_inc  = win_err_q + 8'd1;

   always_comb begin
      state_d     = state_q;
      w_d         = w_q;
      seed_cnt_d  = seed_cnt_q;
      win_bits_d  = win_bits_q;
      win_err_d   = win_err_q;
      err_pulse_d = 1'b0;
      err_count_d = err_count_q;
      bit_count_d = bit_count_q;

      if (clear) begin
         state_d     = SEED;
         w_d         = 8'h00;
         seed_cnt_d  = 3'd0;
         win_bits_d  = 8'd0;
         win_err_d   = 8'd0;
         err_count_d = 16'd0;
         bit_count_d = 16'd0;
      end else if (mon.in_valid) begin
         w_d = {mon.in_bit, w_q[7:1]};
         unique case (state_q)
            SEED: begin
               if (seed_cnt_q == 3'd7) begin
                  state_d    = LOCKED;
                  seed_cnt_d = 3'd0;
               end else begin
                  seed_cnt_d = seed_cnt_q + 3'd1;
               end
            end
            LOCKED: begin
               if (bit_count_q != 16'hFFFF) bit_count_d = bit_count_q + 16'd1;
               win_bits_d = win_bits_inc;
               if (mismatch) begin
                  err_pulse_d = 1'b1;
                  win_err_d   = win_err_inc;
                  if (err_count_q != 16'hFFFF) err_count_d = err_count_q + 16'd1;
               end
               // Loss of lock takes precedence over window rollover; both zero the window.
               if (mismatch && (win_err_inc == LOSS_C)) begin
                  state_d    = SEED;
                  seed_cnt_d = 3'd0;
                  win_bits_d = 8'd0;
                  win_err_d  = 8'd0;
               end else if (win_bits_inc == WIN_LEN_C) begin
                  win_bits_d = 8'd0;
                  win_err_d  = 8'd0;
               end
            end
            default: state_d = SEED;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= SEED;
         w_q         <= 8'h00;
         seed_cnt_q  <= 3'd0;
         win_bits_q  <= 8'd0;
         win_err_q   <= 8'd0;
         err_pulse_q <= 1'b0;
         err_count_q <= 16'd0;
         bit_count_q <= 16'd0;
      end else begin
         state_q     <= state_d;
         w_q         <= w_d;
         seed_cnt_q  <= seed_cnt_d;
         win_bits_q  <= win_bits_d;
         win_err_q   <= win_err_d;
         err_pulse_q <= err_pulse_d;
         err_count_q <= err_count_d;
         bit_count_q <= bit_count_d;
      end
   end

   assign mon.locked    = (state_q == LOCKED);
   assign mon.err_pulse = err_pulse_q;
   assign mon.err_count = err_count_q;
   assign mon.bit_count = bit_count_q;

endmodule

// File: tb/tb_prbs_checker.sv
// Bench for prbs_checker: default instance A for functional tests, wide-window instance B for saturation.
module tb_prbs_checker;

   localparam int WL_B = 255;
   localparam int TH_B = 255;

   logic clk;
   logic rst_n;
   logic clr_a, clr_b;

   prbs_checker_if ifa ();
   prbs_checker_if ifb ();

   prbs_checker u_dut_a (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr_a),
      .mon   (ifa.slave)
   );

   prbs_checker #(.WIN_LEN(WL_B), .LOSS_THRESH(TH_B)) u_dut_b (
      .clk   (clk),
      .rst_n (rst_n),
      .clear (clr_b),
      .mon   (ifb.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Reference model: the last eight stream bits (oldest first) and counters per instance.
   bit hq0[$];
   bit hq1[$];
   bit m_lock[2];
   bit m_pulse[2];
   int m_seedn[2], m_wbits[2], m_werr[2], m_errc[2], m_bitc[2];
   int m_wl[2];
   int m_th[2];

   function automatic void model_reset(int k);
      if (k == 0) begin
         hq0.delete();
         for (int i = 0; i < 8; i++) hq0.push_back(1'b0);
      end else begin
         hq1.delete();
         for (int i = 0; i < 8; i++) hq1.push_back(1'b0);
      end
      m_lock[k] = 1'b0; m_pulse[k] = 1'b0; m_seedn[k] = 0;
      m_wbits[k] = 0; m_werr[k] = 0; m_errc[k] = 0; m_bitc[k] = 0;
   endfunction

   // Next generator bit from the last eight stream bits.
   function automatic bit pred(int k);
      bit h[8];
      int ones;
      for (int i = 0; i < 8; i++) h[i] = (k == 0) ? hq0[i] : hq1[i];
      ones = 0;
      for (int i = 1; i < 8; i++) ones += int'(h[i]);
      return (h[0] ^ h[1] ^ h[2] ^ h[3]) ^ (ones == 0);
   endfunction

   function automatic void model_step(int k, bit v, bit b, bit c);
      bit p, dummy;
      m_pulse[k] = 1'b0;
      if (c) begin
         model_reset(k);
      end else if (v) begin
         if (m_lock[k]) begin
            p = pred(k);
            if (m_bitc[k] < 65535) m_bitc[k]++;
            m_wbits[k]++;
            if (b != p) begin
               if (m_errc[k] < 65535) m_errc[k]++;
               m_werr[k]++;
               m_pulse[k] = 1'b1;
            end
            if (b != p && m_werr[k] == m_th[k]) begin
               m_lock[k] = 1'b0; m_seedn[k] = 0; m_wbits[k] = 0; m_werr[k] = 0;
            end else if (m_wbits[k] == m_wl[k]) begin
               m_wbits[k] = 0; m_werr[k] = 0;
            end
         end else begin
            m_seedn[k]++;
            if (m_seedn[k] == 8) begin
               m_lock[k] = 1'b1; m_seedn[k] = 0;
            end
         end
         if (k == 0) begin hq0.push_back(b); dummy = hq0.pop_front(); end
         else        begin hq1.push_back(b); dummy = hq1.pop_front(); end
      end
   endfunction

   function automatic logic [33:0] obs(int k);
      if (k == 0) return {ifa.locked, ifa.err_pulse, ifa.err_count, ifa.bit_count};
      return {ifb.locked, ifb.err_pulse, ifb.err_count, ifb.bit_count};
   endfunction

   function automatic logic [33:0] expv(int k);
      logic [15:0] e, bc;
      e  = m_errc[k][15:0];
      bc = m_bitc[k][15:0];
      return {m_lock[k], m_pulse[k], e, bc};
   endfunction

   // One clock: inputs set at negedge, model advanced at posedge, outputs sampled 1 unit later.
   task automatic drive(int k, bit v, bit b, bit c);
      @(negedge clk);
      if (k == 0) begin ifa.in_valid = v; ifa.in_bit = b; clr_a = c; end
      else        begin ifb.in_valid = v; ifb.in_bit = b; clr_b = c; end
      @(posedge clk);
      model_step(k, v, b, c);
      #1;
      ifa.in_valid = 1'b0; ifa.in_bit = 1'b0; clr_a = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_bit = 1'b0; clr_b = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      model_reset(0);
      model_reset(1);
      repeat (3) @(posedge clk);
      #1;
      checks++;
      if (obs(0) !== 34'h0) begin errors++; $display("FAIL reset_a got %h want %h", obs(0), 34'h0); end
      checks++;
      if (obs(1) !== 34'h0) begin errors++; $display("FAIL reset_b got %h want %h", obs(1), 34'h0); end
      @(negedge clk);
      rst_n = 1'b1;
      drive(0, 1'b0, 1'b0, 1'b0);
      checks++;
      if (obs(0) !== expv(0)) begin errors++; $display("FAIL reset_idle got %h want %h", obs(0), expv(0)); end
   endtask

   task automatic test_clean();
      bit seed[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      bit tail[2] = '{1'b0, 1'b1};
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) begin
         drive(0, 1'b1, seed[i], 1'b0);
         checks++;
         if (obs(0) !== expv(0)) begin errors++; $display("FAIL clean_seed bit %0d got %h want %h", i, obs(0), expv(0)); end
      end
      checks++;
      if (ifa.locked !== 1'b1) begin errors++; $display("FAIL clean_lock got %b want 1", ifa.locked); end
      for (int i = 0; i < 2; i++) begin
         drive(0, 1'b1, tail[i], 1'b0);
         checks++;
         if (ifa.err_pulse !== 1'b0) begin errors++; $display("FAIL clean_pulse bit %0d got %b want 0", i, ifa.err_pulse); end
      end
      checks++;
      if (ifa.bit_count !== 16'd2 || ifa.err_count !== 16'd0)
         begin errors++; $display("FAIL clean_counts got bc=%0d ec=%0d want bc=2 ec=0", ifa.bit_count, ifa.err_count); end
   endtask

   task automatic test_single_error();
      bit seed[8] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) drive(0, 1'b1, seed[i], 1'b0);
      drive(0, 1'b1, 1'b1, 1'b0);
      checks++;
      if ({ifa.locked, ifa.err_pulse, ifa.err_count} !== {1'b1, 1'b1, 16'd1})
         begin errors++; $display("FAIL single_err got lk=%b p=%b ec=%0d want lk=1 p=1 ec=1", ifa.locked, ifa.err_pulse, ifa.err_count); end
      for (int i = 0; i < 20; i++) begin
         drive(0, 1'b1, pred(0), 1'b0);
         checks++;
         if (obs(0) !== expv(0) || ifa.err_pulse !== 1'b0)
            begin errors++; $display("FAIL single_follow bit %0d got %h want %h", i, obs(0), expv(0)); end
      end
   endtask

   task automatic test_loss();
      bit b;
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'($urandom), 1'b0);
      for (int i = 1; i <= 7; i++) begin
         b = pred(0) ^ (i == 2 || i == 4 || i == 5 || i == 7);
         drive(0, 1'b1, b, 1'b0);
         checks++;
         if (obs(0) !== expv(0)) begin errors++; $display("FAIL loss_bit %0d got %h want %h", i, obs(0), expv(0)); end
      end
      checks++;
      if ({ifa.locked, ifa.err_pulse, ifa.err_count} !== {1'b0, 1'b1, 16'd4})
         begin errors++; $display("FAIL loss_edge got lk=%b p=%b ec=%0d want lk=0 p=1 ec=4", ifa.locked, ifa.err_pulse, ifa.err_count); end
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1'b1, 1'($urandom), 1'b0);
         checks++;
         if (ifa.locked !== (i == 8)) begin errors++; $display("FAIL relock bit %0d got %b want %b", i, ifa.locked, (i == 8)); end
      end
      checks++;
      if (ifa.err_count !== 16'd4) begin errors++; $display("FAIL loss_retain got %0d want 4", ifa.err_count); end
   endtask

   task automatic test_rollover();
      bit e;
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 8; i++) drive(0, 1'b1, 1'($urandom), 1'b0);
      for (int i = 1; i <= 32; i++) begin
         e = (i == 1 || i == 6 || i == 11 || i == 17 || i == 24 || i == 32);
         drive(0, 1'b1, pred(0) ^ e, 1'b0);
         checks++;
         if (obs(0) !== expv(0) || ifa.locked !== 1'b1)
            begin errors++; $display("FAIL rollover bit %0d got %h want %h", i, obs(0), expv(0)); end
      end
      checks++;
      if (ifa.err_count !== 16'd6) begin errors++; $display("FAIL rollover_count got %0d want 6", ifa.err_count); end
   endtask

   task automatic test_gaps_clear();
      int sent = 0;
      bit b;
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 3000 && sent < 300; cyc++) begin
         if ($urandom_range(2, 0) == 0) begin
            drive(0, 1'b0, 1'($urandom), 1'b0);
         end else begin
            b = (sent < 8) ? 1'($urandom) : pred(0);
            drive(0, 1'b1, b, 1'b0);
            sent++;
         end
         checks++;
         if (obs(0) !== expv(0)) begin errors++; $display("FAIL gaps cycle %0d got %h want %h", cyc, obs(0), expv(0)); end
      end
      checks++;
      if (sent != 300 || ifa.bit_count !== 16'd292 || ifa.err_count !== 16'd0)
         begin errors++; $display("FAIL gaps_totals got sent=%0d bc=%0d ec=%0d want 300/292/0", sent, ifa.bit_count, ifa.err_count); end
      drive(0, 1'b1, 1'b1, 1'b1);
      checks++;
      if (obs(0) !== 34'h0) begin errors++; $display("FAIL clear_valid got %h want %h", obs(0), 34'h0); end
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1'b1, 1'($urandom), 1'b0);
         checks++;
         if (ifa.locked !== (i == 8)) begin errors++; $display("FAIL clear_reseed bit %0d got %b want %b", i, ifa.locked, (i == 8)); end
      end
   endtask

   task automatic test_saturation();
      int injected = 0;
      bit b;
      drive(1, 1'b0, 1'b0, 1'b1);
      for (int cyc = 0; cyc < 80000 && injected < 70000; cyc++) begin
         if (m_lock[1]) begin b = ~pred(1); injected++; end
         else b = 1'($urandom);
         drive(1, 1'b1, b, 1'b0);
         if ((cyc % 4096) == 0) begin
            checks++;
            if (obs(1) !== expv(1)) begin errors++; $display("FAIL sat_track cycle %0d got %h want %h", cyc, obs(1), expv(1)); end
         end
      end
      checks++;
      if (injected < 70000) begin errors++; $display("FAIL sat_budget got %0d errors want 70000", injected); end
      checks++;
      if (ifb.err_count !== 16'hFFFF || ifb.bit_count !== 16'hFFFF)
         begin errors++; $display("FAIL sat_hold got ec=%h bc=%h want FFFF/FFFF", ifb.err_count, ifb.bit_count); end
      checks++;
      if (obs(1) !== expv(1)) begin errors++; $display("FAIL sat_final got %h want %h", obs(1), expv(1)); end
   endtask

   task automatic test_async_reset();
      drive(0, 1'b0, 1'b0, 1'b1);
      for (int i = 0; i < 12; i++) drive(0, 1'b1, (i < 8) ? 1'($urandom) : pred(0), 1'b0);
      checks++;
      if (ifa.locked !== 1'b1 || ifa.bit_count !== 16'd4)
         begin errors++; $display("FAIL pre_reset got lk=%b bc=%0d want lk=1 bc=4", ifa.locked, ifa.bit_count); end
      #2;
      rst_n = 1'b0;
      #1;
      model_reset(0);
      model_reset(1);
      checks++;
      if (obs(0) !== 34'h0) begin errors++; $display("FAIL async_reset_a got %h want %h", obs(0), 34'h0); end
      checks++;
      if (obs(1) !== 34'h0) begin errors++; $display("FAIL async_reset_b got %h want %h", obs(1), 34'h0); end
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         drive(0, 1'b1, 1'($urandom), 1'b0);
         checks++;
         if (ifa.locked !== (i == 8)) begin errors++; $display("FAIL post_reset_seed bit %0d got %b want %b", i, ifa.locked, (i == 8)); end
      end
   endtask

   initial begin
      m_wl[0] = 16;   m_th[0] = 4;
      m_wl[1] = WL_B; m_th[1] = TH_B;
      clr_a = 1'b0; clr_b = 1'b0;
      ifa.in_valid = 1'b0; ifa.in_bit = 1'b0;
      ifb.in_valid = 1'b0; ifb.in_bit = 1'b0;
      test_reset();
      test_clean();
      test_single_error();
      test_loss();
      test_rollover();
      test_gaps_clear();
      test_saturation();
      test_async_reset();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
